multiplicador4b_seq: RTL and testbench

MULTIPLICADOR4B_SEQ -- requirements
Module: multiplicador4b_seq

---
 rtl/multiplicador4b_seq.sv | 168 ++++++++++++++++
 tb/tb_multiplicador4b_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador4b_seq.sv
// multiplicador4b_seq -- sequential 4x4 unsigned shift-add multiplier.
//
// One operation takes 4 CALC cycles followed by a single FIM cycle in which
// pronto pulses and produto holds the new result. The add step is performed by
// a single somador4b instance with its carry-in tied low.
//
// Optional feature: define MULT_ZERO_SKIP_EN to let a zero operand bypass
// CALC. The block then goes straight from OCIOSO to FIM with produto = 0.
//
// Ports (multiplicador4b_seq):
//   clk      in   1  single clock, rising edge
//   rst      in   1  synchronous active-high reset
//   inicio   in   1  start request, honoured only in OCIOSO
//   a        in   4  multiplicand (unsigned), captured on the accepting edge
//   b        in   4  multiplier (unsigned), captured on the accepting edge
//   ocupado  out  1  high while in CALC
//   pronto   out  1  one-cycle pulse in FIM, produto valid
//   produto  out  8  registered product, held until the next result
//
// Ports (somador4b):
//   a, b     in   4  addends
//   cin      in   1  carry in
//   s        out  4  sum
//   cout     out  1  carry out

module somador4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// state  | meaning
// OCIOSO | idle, waiting for inicio
// CALC   | one shift-add step per cycle, 4 cycles
// FIM    | result valid, pronto high for one cycle
module multiplicador4b_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       ocupado,
  output logic       pronto,
  output logic [7:0] produto
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  reg_m;
  logic [3:0]  reg_p;
  logic [3:0]  reg_q;
  logic [1:0]  cont;

  logic [3:0]  addend;
  logic [3:0]  soma_s;
  logic        soma_cout;
  logic [4:0]  soma_x;
  logic        zero_op;
  logic        last_step;

  // Only the multiplier LSB decides whether M or zero is added this step.
  assign addend = reg_q[0] ? reg_m : 4'h0;

  somador4b u_somador (
    .a    (reg_p),
    .b    (addend),
    .cin  (1'b0),
    .s    (soma_s),
    .cout (soma_cout)
  );

  assign soma_x    = {soma_cout, soma_s};
  assign last_step = (cont == 2'd3);

`ifdef MULT_ZERO_SKIP_EN
  assign zero_op = (a == 4'h0) || (b == 4'h0);
`else
  assign zero_op = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OCIOSO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      OCIOSO: begin
        if (inicio) begin
          state_next = zero_op ? FIM : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_next = FIM;
        end
      end
      FIM: begin
        state_next = OCIOSO;
      end
      default: begin
        state_next = OCIOSO;
      end
    endcase
  end

  // Outputs
  always_comb begin
    ocupado = (state == CALC);
    pronto  = (state == FIM);
  end

  // Datapath: {P,Q} is the running partial product, shifted right each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_m   <= 4'h0;
      reg_p   <= 4'h0;
      reg_q   <= 4'h0;
      cont    <= 2'd0;
      produto <= 8'h00;
    end else begin
      unique case (state)
        OCIOSO: begin
          if (inicio) begin
            reg_m <= a;
            reg_q <= b;
            reg_p <= 4'h0;
            cont  <= 2'd0;
            if (zero_op) begin
              produto <= 8'h00;
            end
          end
        end
        CALC: begin
          reg_p <= soma_x[4:1];
          reg_q <= {soma_x[0], reg_q[3:1]};
          cont  <= cont + 2'd1;
          // Load the product from the post-shift value, not the old {P,Q}.
          if (last_step) begin
            produto <= {soma_x[4:1], soma_x[0], reg_q[3:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador4b_seq.sv
// Self-checking bench for multiplicador4b_seq. A cycle-level reference model
// tracks how many cycles remain in the current job and which product is due;
// a compare process checks ocupado/pronto/produto against it every cycle.
// Directed jobs additionally pin the result and latency to literal values.

module tb_multiplicador4b_seq;

  logic       clk;
  logic       rst;
  logic       inicio;
  logic [3:0] a;
  logic [3:0] b;
  logic       ocupado;
  logic       pronto;
  logic [7:0] produto;

  int checks = 0;
  int errors = 0;

`ifdef MULT_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 5;
`endif

  multiplicador4b_seq dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .a       (a),
    .b       (b),
    .ocupado (ocupado),
    .pronto  (pronto),
    .produto (produto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: left = cycles still to run in the current job
  // (5..2 busy, 1 = result cycle, 0 = idle).
  int         m_left = 0;
  logic [7:0] m_pending = 8'h00;
  logic [7:0] m_prod = 8'h00;
  logic       chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_prod = 8'h00;
    end else begin
      if (m_left == 0) begin
        if (inicio) begin
          m_pending = 8'(int'(a) * int'(b));
`ifdef MULT_ZERO_SKIP_EN
          m_left = (a == 4'h0 || b == 4'h0) ? 1 : 5;
`else
          m_left = 5;
`endif
        end
      end else begin
        m_left = m_left - 1;
      end
      if (m_left == 1) m_prod = m_pending;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ocupado !== (m_left >= 2)) begin
        errors++;
        $display("FAIL ocupado t=%0t got=%b exp=%b", $time, ocupado, (m_left >= 2));
      end
      checks++;
      if (pronto !== (m_left == 1)) begin
        errors++;
        $display("FAIL pronto t=%0t got=%b exp=%b", $time, pronto, (m_left == 1));
      end
      checks++;
      if (produto !== m_prod) begin
        errors++;
        $display("FAIL produto t=%0t got=%h exp=%h", $time, produto, m_prod);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Start one job, optionally scramble a/b during CALC, wait for pronto,
  // and check result and latency against literal expectations.
  task automatic run_job(input logic [3:0] va, input logic [3:0] vb,
                         input logic [7:0] exp_prod, input int exp_lat,
                         input bit scramble);
    int cnt;
    a = va;
    b = vb;
    inicio = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (cnt == 1) begin
        inicio = 1'b0;
        if (scramble) begin
          a = 4'($urandom);
          b = 4'($urandom);
        end
      end
    end while (!pronto && cnt < 12);
    if (!pronto) begin
      errors++;
      $display("FAIL timeout a=%0d b=%0d waited=%0d", va, vb, cnt);
    end else begin
      expect_eq("job_produto", produto, exp_prod);
      expect_eq("job_latency", cnt, exp_lat);
    end
    tick();
  endtask

  initial begin
    int plist[$];
    int pcount;
    rst = 1'b1;
    inicio = 1'b0;
    a = 4'h0;
    b = 4'h0;
    tick();
    chk_en = 1'b1;
    tick();
    expect_eq("reset_ocupado", ocupado, 0);
    expect_eq("reset_pronto", pronto, 0);
    expect_eq("reset_produto", produto, 8'h00);
    rst = 1'b0;

    // 15*15, result must hold afterwards
    run_job(4'd15, 4'd15, 8'hE1, 5, 1'b0);
    repeat (9) tick();
    expect_eq("hold_E1", produto, 8'hE1);

    // Operands scrambled during CALC have no effect
    run_job(4'd3, 4'd5, 8'h0F, 5, 1'b1);
    run_job(4'd9, 4'd12, 8'h6C, 5, 1'b1);

    // Zero operands
    run_job(4'd0, 4'd9, 8'h00, ZERO_LAT, 1'b0);
    run_job(4'd15, 4'd0, 8'h00, ZERO_LAT, 1'b0);

    // inicio held high: one job every 6 cycles
    a = 4'd7;
    b = 4'd6;
    inicio = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (pronto) begin
        plist.push_back(i);
        expect_eq("held_produto", produto, 8'h2A);
      end
    end
    inicio = 1'b0;
    tick();
    tick();
    expect_eq("held_pulses", plist.size(), 4);
    for (int i = 1; i < plist.size(); i++) begin
      expect_eq("held_period", plist[i] - plist[i-1], 6);
    end

    // inicio pulsed during CALC and during FIM: exactly one job
    a = 4'd4;
    b = 4'd3;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    pcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2 || pronto) inicio = 1'b1;
      tick();
      inicio = 1'b0;
      if (pronto) pcount++;
    end
    expect_eq("no_queue_pulses", pcount, 1);
    expect_eq("no_queue_produto", produto, 8'h0C);

    // Reset in the 2nd CALC cycle aborts the job
    a = 4'd11;
    b = 4'd13;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_eq("abort_ocupado", ocupado, 0);
    expect_eq("abort_pronto", pronto, 0);
    expect_eq("abort_produto", produto, 8'h00);
    pcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pronto) pcount++;
    end
    expect_eq("abort_no_pronto", pcount, 0);
    run_job(4'd2, 4'd8, 8'h10, 5, 1'b0);

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_job(4'(i), 4'(j), 8'(i * j),
                (i == 0 || j == 0) ? ZERO_LAT : 5, 1'b0);
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
